sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the SRAM-like bus used between the CPU core and memory: inst port, data port, and future masters such as cache refill or a debug port.
- Arbitrates address phases, tracks outstanding transactions in an ID FIFO, and routes each slave data_ok/rdata back to the master that issued the request.
- Successor to fixed two-port wiring: generalised master count, outstanding depth and arbitration mode, plus protocol-error detection.

Parameters:
- N_MASTERS, 2, number of SRAM-like masters (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- MAX_OUTST, 4, maximum accepted-but-unanswered transactions (1..16).
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- m_req  in  N_MASTERS  per-master request.
- m_wr  in  N_MASTERS  per-master write flag.
- m_size  in  2*N_MASTERS  per-master size, master i at [2i+1:2i].
- m_addr  in  ADDR_W*N_MASTERS  per-master address.
- m_wstrb  in  (DATA_W/8)*N_MASTERS  per-master byte strobes.
- m_wdata  in  DATA_W*N_MASTERS  per-master write data.
- m_addr_ok  out  N_MASTERS  per-master address accept.
- m_data_ok  out  N_MASTERS  per-master data return.
- m_rdata  out  DATA_W  read data, broadcast to all masters.
- s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata  out  1/1/2/ADDR_W/DATA_W/8/DATA_W  slave request channel.
- s_addr_ok  in  1  slave address accept.
- s_data_ok  in  1  slave data return.
- s_rdata  in  DATA_W  slave read data.
- outst_cnt  out  $clog2(MAX_OUTST+1)  current outstanding count.
- proto_err  out  1  sticky protocol error.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (resetn). When resetn is low, all registers clear immediately:
  - lock_vld=0, rr_ptr=0, FIFO empty, outst_cnt=0, proto_err=0.
  - s_req, m_addr_ok and m_data_ok are forced to 0 while resetn is low.
- Grant selection (combinational, used only when lock_vld=0):
  - RR_MODE=1: first requesting master at or after rr_ptr, wrapping modulo N_MASTERS.
  - RR_MODE=0: lowest-index requesting master.
- Effective grant: gnt = lock_vld ? lock_id : selected master.
- s_req = m_req[gnt] & (outst_cnt != MAX_OUTST). The s_* request fields mux from master gnt.
- m_addr_ok[gnt] = s_addr_ok & s_req. All other m_addr_ok bits are 0.
- Lock rule: if s_req & !s_addr_ok, set lock_vld=1 and lock_id=gnt. This keeps the slave request stable until accepted, even if a higher-priority master raises req.
- Lock release:
  - On s_req & s_addr_ok, clear lock.
  - If the locked master drops m_req before acceptance, clear lock and set proto_err.
- Acceptance: on s_req & s_addr_ok, push gnt into the ID FIFO (depth MAX_OUTST). In RR mode, set rr_ptr = (gnt+1) mod N_MASTERS.
- Data return: on s_data_ok with FIFO non-empty, m_data_ok[head]=1 in the same cycle, m_rdata=s_rdata, and the head is popped. Returns are in order; the slave must answer in acceptance order.
- Data return on empty FIFO: s_data_ok with an empty FIFO is ignored (no m_data_ok) and sets proto_err.
- Simultaneous push and pop: outst_cnt is unchanged. The FIFO pointers wrap modulo MAX_OUTST.
- Full FIFO: s_req is held at 0 while outst_cnt==MAX_OUTST, with no same-cycle bypass from a pop. Request acceptance resumes the cycle after outst_cnt drops.
- Latency: zero added cycles on both the address and data paths, since both are pure mux paths.
- m_rdata equals s_rdata at all times. Masters qualify it with their own m_data_ok.
- proto_err clears only on reset.

Test Plan:
- Single master 0 read: m_req=01 at addr 0x1000, s_addr_ok=1 in the same cycle -> s_addr=0x1000, m_addr_ok=01, outst_cnt=1. Next cycle s_data_ok=1 with s_rdata=0xDEADBEEF -> m_data_ok=01, m_rdata=0xDEADBEEF, outst_cnt=0.
- RR fairness: N_MASTERS=3, all m_req held at 1, s_addr_ok=1 every cycle, instant data -> grant sequence 0,1,2,0,1,2.
- RR_MODE=0 with the same stimulus -> master 0 granted every cycle.
- Lock: master 1 granted and s_addr_ok held at 0 for 3 cycles while master 0 raises req -> s_req stays on master 1's address until accepted, then master 0 is granted next.
- Full and in-order return: MAX_OUTST=4, accept 4 requests from masters 1,0,1,1 -> s_req=0 on the 5th request and outst_cnt=4. Four s_data_ok pulses -> m_data_ok sequence 10,01,10,10, outst_cnt returns to 0.
- Errors and reset: s_data_ok with an empty FIFO -> no m_data_ok, proto_err=1. Assert resetn=0 mid-transaction with 2 outstanding -> outst_cnt=0, proto_err=0, s_req=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
`default_nettype none
// sram_like_arbiter_if: master-side and slave-side SRAM-like bus bundle for the arbiter.
// Revision 1.0
interface sram_like_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [N_MASTERS-1:0]            m_req;
  logic [N_MASTERS-1:0]            m_wr;
  logic [2*N_MASTERS-1:0]          m_size;
  logic [ADDR_W*N_MASTERS-1:0]     m_addr;
  logic [(DATA_W/8)*N_MASTERS-1:0] m_wstrb;
  logic [DATA_W*N_MASTERS-1:0]     m_wdata;
  logic [N_MASTERS-1:0]            m_addr_ok;
  logic [N_MASTERS-1:0]            m_data_ok;
  logic [DATA_W-1:0]               m_rdata;

  logic                            s_req;
  logic                            s_wr;
  logic [1:0]                      s_size;
  logic [ADDR_W-1:0]               s_addr;
  logic [DATA_W/8-1:0]             s_wstrb;
  logic [DATA_W-1:0]               s_wdata;
  logic                            s_addr_ok;
  logic                            s_data_ok;
  logic [DATA_W-1:0]               s_rdata;

  // Arbiter view: serves the masters, drives the slave request channel.
  modport slave (
    input  m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    output s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata,
    input  s_addr_ok, s_data_ok, s_rdata
  );

  // Environment view: masters and the memory slave around the arbiter.
  modport master (
    output m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    input  s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata,
    output s_addr_ok, s_data_ok, s_rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// sram_like_arbiter: N-master to 1-slave SRAM-like arbiter with in-order ID tracking.
// Revision 1.0
module sram_like_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int RR_MODE   = 1
) (
  input  wire                             clk,
  input  wire                             resetn,
  sram_like_arbiter_if.slave              bus,
  output logic [$clog2(MAX_OUTST+1)-1:0]  outst_cnt,
  output logic                            proto_err
);
  localparam int IDW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW  = $clog2(MAX_OUTST + 1);
  localparam int SW  = DATA_W / 8;

  logic           lock_vld;
  logic [IDW-1:0] lock_id;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] head_id;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [IDW-1:0] id_fifo [MAX_OUTST];
  logic           gnt_req;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  function automatic logic [IDW-1:0] wrap_id(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_MASTERS) s = s - N_MASTERS;
    return IDW'(s);
  endfunction

  // Descending scan so the candidate closest to the start point wins.
  always_comb begin
    sel = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (RR_MODE != 0) begin
        if (bus.m_req[wrap_id(rr_ptr, k)]) sel = wrap_id(rr_ptr, k);
      end else if (bus.m_req[k]) begin
        sel = IDW'(k);
      end
    end
  end

  assign gnt = lock_vld ? lock_id : sel;

  always_comb begin
    gnt_req     = 1'b0;
    bus.s_wr    = 1'b0;
    bus.s_size  = '0;
    bus.s_addr  = '0;
    bus.s_wstrb = '0;
    bus.s_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (gnt == IDW'(i)) begin
        gnt_req     = bus.m_req[i];
        bus.s_wr    = bus.m_wr[i];
        bus.s_size  = bus.m_size[2*i +: 2];
        bus.s_addr  = bus.m_addr[ADDR_W*i +: ADDR_W];
        bus.s_wstrb = bus.m_wstrb[SW*i +: SW];
        bus.s_wdata = bus.m_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign full        = (outst_cnt == CW'(MAX_OUTST));
  assign empty       = (outst_cnt == '0);
  assign bus.s_req   = resetn & gnt_req & ~full;
  assign push        = bus.s_req & bus.s_addr_ok;
  assign pop         = resetn & bus.s_data_ok & ~empty;
  assign head_id     = id_fifo[rd_ptr];
  assign bus.m_rdata = bus.s_rdata;

  always_comb begin
    bus.m_addr_ok = '0;
    bus.m_data_ok = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      bus.m_addr_ok[i] = push & (gnt == IDW'(i));
      bus.m_data_ok[i] = pop & (head_id == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_vld  <= 1'b0;
      lock_id   <= '0;
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      outst_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      // A locked master that withdraws its request breaks the hold-until-accept rule.
      if (lock_vld && !gnt_req) begin
        lock_vld  <= 1'b0;
        proto_err <= 1'b1;
      end else if (bus.s_req && !bus.s_addr_ok) begin
        lock_vld <= 1'b1;
        lock_id  <= gnt;
      end else if (push) begin
        lock_vld <= 1'b0;
      end

      if (bus.s_data_ok && empty) proto_err <= 1'b1;

      if (push) begin
        wr_ptr <= (wr_ptr == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr + PW'(1);
        if (RR_MODE != 0) rr_ptr <= wrap_id(gnt, 1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr + PW'(1);

      if (push && !pop)      outst_cnt <= outst_cnt + CW'(1);
      else if (pop && !push) outst_cnt <= outst_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= gnt;
  end
endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// tb_sram_like_arbiter: randomized scoreboard bench, round-robin and fixed-priority instances.
// Revision 1.0
module tb_sram_like_arbiter;
  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_like_arbiter_if #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) ifa ();
  sram_like_arbiter_if #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) ifb ();

  logic [CW-1:0] cnt_a, cnt_b;
  logic          err_a, err_b;

  sram_like_arbiter #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .RR_MODE(1)) dut_rr (
    .clk(clk), .resetn(resetn), .bus(ifa.slave), .outst_cnt(cnt_a), .proto_err(err_a));
  sram_like_arbiter #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .RR_MODE(0)) dut_fp (
    .clk(clk), .resetn(resetn), .bus(ifb.slave), .outst_cnt(cnt_b), .proto_err(err_b));

  typedef struct {
    int             inst;
    logic           s_req;
    logic [AW-1:0]  s_addr;
    logic           s_wr;
    logic [1:0]     s_size;
    logic [DW/8-1:0] s_wstrb;
    logic [DW-1:0]  s_wdata;
    logic [NM-1:0]  aok;
    logic [NM-1:0]  dok;
    int             cnt;
    logic           err;
    logic [DW-1:0]  rdata;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Stimulus shared by both instances
  logic [NM-1:0]        req, wr;
  logic [2*NM-1:0]      p_size;
  logic [AW*NM-1:0]     p_addr;
  logic [(DW/8)*NM-1:0] p_wstrb;
  logic [DW*NM-1:0]     p_wdata;
  logic                 sa_ok, sd_ok;
  logic [DW-1:0]        rdata_v;

  // Reference model state, index 0 = round-robin, 1 = fixed priority
  bit lock [2];
  int lock_id [2];
  int rr [2];
  bit err [2];
  int idq [2][$];

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      lock[j] = 1'b0; lock_id[j] = 0; rr[j] = 0; err[j] = 1'b0;
      idq[j].delete();
    end
  endtask

  task automatic drive();
    ifa.m_req = req;   ifb.m_req = req;
    ifa.m_wr = wr;     ifb.m_wr = wr;
    ifa.m_size = p_size;   ifb.m_size = p_size;
    ifa.m_addr = p_addr;   ifb.m_addr = p_addr;
    ifa.m_wstrb = p_wstrb; ifb.m_wstrb = p_wstrb;
    ifa.m_wdata = p_wdata; ifb.m_wdata = p_wdata;
    ifa.s_addr_ok = sa_ok; ifb.s_addr_ok = sa_ok;
    ifa.s_data_ok = sd_ok; ifb.s_data_ok = sd_ok;
    ifa.s_rdata = rdata_v; ifb.s_rdata = rdata_v;
  endtask

  task automatic randomize_inputs(input int p_aok, input int p_dok);
    for (int i = 0; i < NM; i++) begin
      bit held;
      held = (lock[0] && lock_id[0] == i) || (lock[1] && lock_id[1] == i);
      // Locked masters mostly hold their request; a rare drop exercises the error path.
      if (held) req[i] = ($urandom_range(0, 49) != 0);
      else      req[i] = ($urandom_range(0, 99) < 60);
      wr[i] = $urandom_range(0, 1) == 1;
      p_size[2*i +: 2]      = 2'($urandom_range(0, 3));
      p_addr[AW*i +: AW]    = $urandom;
      p_wstrb[4*i +: 4]     = 4'($urandom_range(0, 15));
      p_wdata[DW*i +: DW]   = $urandom;
    end
    sa_ok = ($urandom_range(0, 99) < p_aok);
    if (idq[0].size() > 0 || idq[1].size() > 0) sd_ok = ($urandom_range(0, 99) < p_dok);
    else sd_ok = ($urandom_range(0, 29) == 0);
    rdata_v = $urandom;
  endtask

  task automatic model_cycle(input int j);
    exp_t e;
    int   g, cnt;
    bit   found;
    cnt = idq[j].size();
    g = 0;
    found = 1'b0;
    if (lock[j]) begin
      g = lock_id[j];
      found = 1'b1;
    end else begin
      for (int k = 0; k < NM; k++) begin
        int idx;
        idx = (j == 0) ? (rr[j] + k) % NM : k;
        if (!found && req[idx]) begin g = idx; found = 1'b1; end
      end
    end
    e.inst    = j;
    e.s_req   = found && req[g] && (cnt != MO);
    e.s_addr  = p_addr[g*AW +: AW];
    e.s_wr    = wr[g];
    e.s_size  = p_size[g*2 +: 2];
    e.s_wstrb = p_wstrb[g*4 +: 4];
    e.s_wdata = p_wdata[g*DW +: DW];
    e.aok     = '0;
    if (e.s_req && sa_ok) e.aok[g] = 1'b1;
    e.dok     = '0;
    e.cnt     = cnt;
    e.err     = err[j];
    e.rdata   = rdata_v;
    if (sd_ok) begin
      if (cnt > 0) begin
        e.dok[idq[j][0]] = 1'b1;
        void'(idq[j].pop_front());
      end else begin
        err[j] = 1'b1;
      end
    end
    if (lock[j] && !req[g]) begin
      lock[j] = 1'b0;
      err[j]  = 1'b1;
    end else if (e.s_req && !sa_ok) begin
      lock[j]    = 1'b1;
      lock_id[j] = g;
    end else if (e.s_req) begin
      lock[j] = 1'b0;
    end
    if (e.s_req && sa_ok) begin
      idq[j].push_back(g);
      if (j == 0) rr[j] = (g + 1) % NM;
    end
    expq.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic           a_sreq, a_swr, a_err;
    logic [AW-1:0]  a_addr;
    logic [1:0]     a_size;
    logic [3:0]     a_wstrb;
    logic [DW-1:0]  a_wdata, a_rdata;
    logic [NM-1:0]  a_aok, a_dok;
    logic [CW-1:0]  a_cnt;
    if (e.inst == 0) begin
      a_sreq = ifa.s_req; a_swr = ifa.s_wr; a_addr = ifa.s_addr; a_size = ifa.s_size;
      a_wstrb = ifa.s_wstrb; a_wdata = ifa.s_wdata; a_rdata = ifa.m_rdata;
      a_aok = ifa.m_addr_ok; a_dok = ifa.m_data_ok; a_cnt = cnt_a; a_err = err_a;
    end else begin
      a_sreq = ifb.s_req; a_swr = ifb.s_wr; a_addr = ifb.s_addr; a_size = ifb.s_size;
      a_wstrb = ifb.s_wstrb; a_wdata = ifb.s_wdata; a_rdata = ifb.m_rdata;
      a_aok = ifb.m_addr_ok; a_dok = ifb.m_data_ok; a_cnt = cnt_b; a_err = err_b;
    end
    chk("s_req", e.inst, 64'(a_sreq), 64'(e.s_req));
    chk("m_addr_ok", e.inst, 64'(a_aok), 64'(e.aok));
    chk("m_data_ok", e.inst, 64'(a_dok), 64'(e.dok));
    chk("outst_cnt", e.inst, 64'(a_cnt), 64'(e.cnt));
    chk("proto_err", e.inst, 64'(a_err), 64'(e.err));
    chk("m_rdata", e.inst, 64'(a_rdata), 64'(e.rdata));
    if (e.s_req) begin
      chk("s_addr", e.inst, 64'(a_addr), 64'(e.s_addr));
      chk("s_wr", e.inst, 64'(a_swr), 64'(e.s_wr));
      chk("s_size", e.inst, 64'(a_size), 64'(e.s_size));
      chk("s_wstrb", e.inst, 64'(a_wstrb), 64'(e.s_wstrb));
      chk("s_wdata", e.inst, 64'(a_wdata), 64'(e.s_wdata));
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_s_req"}, 0, 64'(ifa.s_req), 64'(0));
    chk({tag, "_s_req"}, 1, 64'(ifb.s_req), 64'(0));
    chk({tag, "_addr_ok"}, 0, 64'(ifa.m_addr_ok), 64'(0));
    chk({tag, "_addr_ok"}, 1, 64'(ifb.m_addr_ok), 64'(0));
    chk({tag, "_data_ok"}, 0, 64'(ifa.m_data_ok), 64'(0));
    chk({tag, "_data_ok"}, 1, 64'(ifb.m_data_ok), 64'(0));
    chk({tag, "_cnt"}, 0, 64'(cnt_a), 64'(0));
    chk({tag, "_cnt"}, 1, 64'(cnt_b), 64'(0));
    chk({tag, "_err"}, 0, 64'(err_a), 64'(0));
    chk({tag, "_err"}, 1, 64'(err_b), 64'(0));
  endtask

  // Monitor: compares every expected entry at the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      while (expq.size() > 0) compare(expq.pop_front());
    end
  end

  initial begin
    int p_aok [3];
    int p_dok [3];
    p_aok[0] = 50; p_aok[1] = 90; p_aok[2] = 20;
    p_dok[0] = 50; p_dok[1] = 25; p_dok[2] = 80;
    model_reset();
    randomize_inputs(50, 50);
    req = '1;
    drive();
    #1;
    reset_checks("init");
    for (int ph = 0; ph < 3; ph++) begin
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int c = 0; c < 400; c++) begin
        if (c > 0) begin
          @(posedge clk);
          #1;
        end
        randomize_inputs(p_aok[ph], p_dok[ph]);
        drive();
        model_cycle(0);
        model_cycle(1);
      end
      // Asynchronous reset mid-cycle with requests pending
      @(posedge clk);
      #2;
      randomize_inputs(p_aok[ph], p_dok[ph]);
      req = '1;
      drive();
      resetn = 1'b0;
      #1;
      reset_checks("async_rst");
      @(posedge clk);
      #1;
      reset_checks("held_rst");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
